// File: rtl/bin_to_bcd_comp.sv
// Avalon-MM binary-to-BCD converter feeding the hex display's value register.
// Optional feature macro: BCD_SATURATE_EN (overflow shows all nines instead of value mod 10^DIGITS).
module bin_to_bcd_comp #(
    parameter int BIN_WIDTH = 27,
    parameter int DIGITS    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  address,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic                  read,
    output logic [31:0]           readdata,
    output logic                  out_write,
    output logic [4*DIGITS-1:0]   out_writedata
);

    localparam int SW = 4 * (DIGITS + 1);
    localparam int CW = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [BIN_WIDTH-1:0]   bin_q, bin_d;
    logic [SW-1:0]          scratch_q, scratch_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0]   pend_q, pend_d;
    logic                   pend_vld_q, pend_vld_d;
    logic                   ovf_q, ovf_d;
    logic                   out_write_q, out_write_d;
    logic [4*DIGITS-1:0]    out_wd_q, out_wd_d;

    logic                   value_wr;
    logic                   ovf_clr;
    logic                   conv_ovf;
    logic                   load;
    logic [BIN_WIDTH-1:0]   load_val;
    logic [SW-1:0]          adj;
    logic [4*DIGITS-1:0]    result;
    logic                   busy;
    logic                   unused_wd;

    assign value_wr  = write && !address;
    assign ovf_clr   = write && address && writedata[2];
    assign conv_ovf  = (scratch_q[SW-1 -: 4] != 4'd0);
    assign unused_wd = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            ovf_q       <= 1'b0;
            out_write_q <= 1'b0;
            out_wd_q    <= '0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            ovf_q       <= ovf_d;
            out_write_q <= out_write_d;
            out_wd_q    <= out_wd_d;
        end
    end

    // IDLE also drains pending so a write landing in DONE is picked up one cycle later.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pend_vld_q || value_wr) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    state_d = pend_vld_q ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Double-dabble correction: any digit >= 5 gets +3 before the shift.
    always_comb begin
        adj = scratch_q;
        for (int k = 0; k < DIGITS + 1; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
        end
    end

`ifdef BCD_SATURATE_EN
    assign result = conv_ovf ? {DIGITS{4'h9}} : scratch_q[4*DIGITS-1:0];
`else
    assign result = scratch_q[4*DIGITS-1:0];
`endif

    always_comb begin
        bin_d       = bin_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        ovf_d       = ovf_q;
        out_write_d = 1'b0;
        out_wd_d    = out_wd_q;
        load        = 1'b0;
        load_val    = writedata[BIN_WIDTH-1:0];

        if (ovf_clr) ovf_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_vld_q) begin
                    load       = 1'b1;
                    load_val   = pend_q;
                    pend_vld_d = 1'b0;
                    if (value_wr) begin
                        pend_d     = writedata[BIN_WIDTH-1:0];
                        pend_vld_d = 1'b1;
                    end
                end else if (value_wr) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                {scratch_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q - CW'(1);
                if (value_wr) begin
                    pend_d     = writedata[BIN_WIDTH-1:0];
                    pend_vld_d = 1'b1;
                end
            end
            DONE: begin
                out_write_d = 1'b1;
                out_wd_d    = result;
                if (conv_ovf) ovf_d = 1'b1;
                if (pend_vld_q) begin
                    load       = 1'b1;
                    load_val   = pend_q;
                    pend_vld_d = 1'b0;
                end
                if (value_wr) begin
                    pend_d     = writedata[BIN_WIDTH-1:0];
                    pend_vld_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (load) begin
            bin_d     = load_val;
            scratch_d = '0;
            cnt_d     = CW'(BIN_WIDTH);
        end
    end

    always_comb begin
        busy     = (state_q != IDLE);
        readdata = 32'd0;
        if (read) begin
            if (address) readdata = {29'd0, ovf_q, pend_vld_q, busy};
            else         readdata = 32'(out_wd_q);
        end
    end

    assign out_write     = out_write_q;
    assign out_writedata = out_wd_q;

endmodule

// File: doc/bin_to_bcd_comp.md
Name: bin_to_bcd_comp

Overview:
Nios-facing Avalon-MM slave that accepts a binary value and converts it to packed BCD using a sequential double-dabble engine (one bit per clock).
- Drives its result as a one-cycle write strobe plus 32-bit data directly into the 8-digit hex display component's value register.
- The display therefore shows decimal instead of hex.
- Status readback lets software poll for busy and overflow.

Parameters:
BIN_WIDTH, 27, number of binary input bits converted (writedata[BIN_WIDTH-1:0]); higher bits ignored
DIGITS, 8, number of BCD digits produced; out_writedata width is 4*DIGITS (must be 32 with defaults)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
address  input  1  0 = value register, 1 = status register
write  input  1  Avalon write strobe, zero wait states
writedata  input  32  write data
read  input  1  Avalon read strobe
readdata  output  32  combinational read data, zero wait states
out_write  output  1  one-cycle strobe to the display component's write
out_writedata  output  32  packed BCD result; digit k is in bits [4k+3:4k]

Behaviour:
- Reset:
  - Synchronous, active-high; one clock with reset=1 clears everything.
  - State=IDLE, pending empty, overflow=0, out_write=0, out_writedata=0.
  - Reset during a conversion aborts it: no out_write pulse, pending value discarded.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: write with address=0 latches writedata[BIN_WIDTH-1:0] into the shift register, clears the BCD scratch (DIGITS+1 digits), loads counter=BIN_WIDTH, and goes to SHIFT.
  - SHIFT: each cycle, add 3 to every scratch digit >=5, then shift {scratch, bin} left by 1 and decrement the counter. After exactly BIN_WIDTH SHIFT cycles, go to DONE.
  - DONE: out_write=1 for exactly this cycle and out_writedata is updated to the result (registered, same edge). If pending is valid, load it and go to SHIFT, clearing pending; otherwise go to IDLE.
- Latency: accept edge E0; out_write high during the cycle following edge E0+BIN_WIDTH+1 (28 cycles with defaults). Back-to-back throughput is one result per BIN_WIDTH+1 cycles.
- Busy: state != IDLE.
- Value write while busy: stored in a one-deep pending register. A later write overwrites pending (last write wins); the earlier value is dropped silently.
- Write and DONE in the same cycle: the write goes to pending and is then consumed at the next opportunity; it is never lost.
- Overflow:
  - After conversion, scratch digit DIGITS (the extra top digit) nonzero means value >= 10^DIGITS.
  - This sets the sticky overflow bit in the DONE cycle.
  - Output content on overflow is governed by the optional feature.
- Status register (address=1, read): bit0 busy, bit1 pending valid, bit2 overflow sticky, others 0.
- Writing address=1 with writedata[2]=1 clears overflow. If the clear coincides with DONE setting overflow, set wins.
- readdata for address=0 returns the current out_writedata. readdata is 0 when read=0.
- out_writedata holds its value between conversions; out_write is 0 except in DONE.

Optional Feature:
BCD_SATURATE_EN
- Defined: on overflow, out_writedata = all digits 9 (0x99999999 by default).
- Undefined: on overflow, out_writedata = low DIGITS digits of the result (value mod 10^DIGITS).
- In both cases the overflow flag is set and the out_write pulse occurs normally.

Test Plan:
- Write 12345678 (0x00BC614E) to addr 0 from IDLE -> exactly one out_write pulse 28 cycles later, out_writedata=0x12345678, status=0.
- Write 0, then 99999999 -> results 0x00000000 and 0x99999999, overflow stays 0.
- Write 100000005 -> overflow=1. With BCD_SATURATE_EN, out_writedata=0x99999999; without it, out_writedata=0x00000005. Write addr 1 data 0x4 -> status bit2 reads 0.
- Write 5, then 6 and 7 while busy -> pulses carry 0x00000005 then 0x00000007 only; status bit1=1 between the 6 and 7 writes and the first DONE.
- Assert reset for one cycle at cycle 10 of a conversion of 42 -> no out_write pulse, out_writedata=0, busy=0. A subsequent write of 42 -> 0x00000042.
- Write 0x08000001 (bit 27 set) -> bit 27 ignored, result 0x00000001.
